accel_run_ctrl: RTL and testbench

- Run controller in front of the accelerator core.
- Owns the load/run sequencing: accepts host initialisation writes for regfile_InexRecur and regfile_state, then raises the core start level and waits for completion or timeout.
- Arbitrates the regfile_state random-write port: the host owns it while idle, and the core FSM write-back owns it while running.
- Replaces the ad-hoc start-level mux in the accelerator top level.

---
 rtl/accel_pkg.sv | 27 ++
 rtl/accel_wr_mux.sv | 55 +++++
 rtl/accel_run_ctrl.sv | 141 ++++++++++++++
 tb/tb_accel_run_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_pkg.sv
// Shared types and widths for the accelerator run controller.
package accel_pkg;

  localparam int ADDR_W = 12;
  localparam int IR_DW  = 32;
  localparam int ST_DW  = 18;
  localparam int CNT_W  = 13;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARM    = 2'd1,
    S_RUN    = 2'd2,
    S_FINISH = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_TIMEOUT = 2'b01,
    ST_ABORT   = 2'b10
  } status_e;

  // Write counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/accel_wr_mux.sv
// Registered host write stage and regfile_state port owner mux.
module accel_wr_mux
  import accel_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              host_fire_i,
  input  logic              host_ok_i,
  input  logic              host_sel_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [IR_DW-1:0]  host_data_i,
  input  logic              run_own_i,
  input  logic              fsm_we_i,
  input  logic [ADDR_W-1:0] fsm_waddr_i,
  input  logic [ST_DW-1:0]  fsm_wdata_i,
  output logic              ir_we_o,
  output logic [ADDR_W-1:0] ir_waddr_o,
  output logic [IR_DW-1:0]  ir_wdata_o,
  output logic              st_we_o,
  output logic [ADDR_W-1:0] st_waddr_o,
  output logic [ST_DW-1:0]  st_wdata_o
);

  logic              wr_vld_q;
  logic              wr_sel_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [IR_DW-1:0]  wr_data_q;

  // Out-of-range writes complete the handshake but never raise a write enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_vld_q  <= 1'b0;
      wr_sel_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_vld_q <= host_fire_i & host_ok_i;
      if (host_fire_i) begin
        wr_sel_q  <= host_sel_i;
        wr_addr_q <= host_addr_i;
        wr_data_q <= host_data_i;
      end
    end
  end

  assign ir_we_o    = wr_vld_q & ~wr_sel_q;
  assign ir_waddr_o = wr_addr_q;
  assign ir_wdata_o = wr_data_q;

  // The core owns the state port during RUN and FINISH so a last write-back survives.
  assign st_we_o    = run_own_i ? fsm_we_i    : (wr_vld_q & wr_sel_q);
  assign st_waddr_o = run_own_i ? fsm_waddr_i : wr_addr_q;
  assign st_wdata_o = run_own_i ? fsm_wdata_i : wr_data_q[ST_DW-1:0];

endmodule

// File: rtl/accel_run_ctrl.sv
// Load/run sequencer in front of the accelerator core: host loads, start level, completion.
module accel_run_ctrl
  import accel_pkg::*;
#(
  parameter int DEPTH   = 4096,
  parameter int TIMEOUT = 1048576,
  parameter int TO_W    = 21
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic              host_sel,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [IR_DW-1:0]  host_data,
  input  logic              host_go,
  input  logic              host_abort,
  output logic              ir_we_o,
  output logic [ADDR_W-1:0] ir_waddr_o,
  output logic [IR_DW-1:0]  ir_wdata_o,
  output logic              st_we_o,
  output logic [ADDR_W-1:0] st_waddr_o,
  output logic [ST_DW-1:0]  st_wdata_o,
  input  logic              fsm_we_i,
  input  logic [ADDR_W-1:0] fsm_waddr_i,
  input  logic [ST_DW-1:0]  fsm_wdata_i,
  output logic              acc_start_o,
  input  logic              acc_done_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [1:0]        status_o,
  output logic              addr_err_o,
  output logic [CNT_W-1:0]  ir_cnt_o,
  output logic [CNT_W-1:0]  st_cnt_o
);

  localparam logic [TO_W-1:0] RUN_LAST = TO_W'(TIMEOUT - 1);

  state_e           state_q;
  status_e          status_q;
  logic             acc_start_q;
  logic             done_q;
  logic             busy_q;
  logic             addr_err_q;
  logic [TO_W-1:0]  run_cnt_q;
  logic [CNT_W-1:0] ir_cnt_q;
  logic [CNT_W-1:0] st_cnt_q;
  logic             accept;
  logic             addr_ok;
  logic             run_own;

  assign host_ready = (state_q == S_IDLE);
  assign accept     = host_valid & host_ready;
  assign addr_ok    = (int'(host_addr) < DEPTH);
  assign run_own    = (state_q == S_RUN) || (state_q == S_FINISH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      status_q    <= ST_OK;
      acc_start_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      run_cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (host_go) begin
            state_q <= S_ARM;
            busy_q  <= 1'b1;
          end
        end
        S_ARM: begin
          state_q     <= S_RUN;
          status_q    <= ST_OK;
          run_cnt_q   <= '0;
          acc_start_q <= 1'b1;
        end
        S_RUN: begin
          run_cnt_q <= run_cnt_q + 1'b1;
          // Completion outranks abort, abort outranks timeout.
          if (acc_done_i || host_abort || run_cnt_q == RUN_LAST) begin
            state_q     <= S_FINISH;
            acc_start_q <= 1'b0;
            done_q      <= 1'b1;
            if (acc_done_i)      status_q <= ST_OK;
            else if (host_abort) status_q <= ST_ABORT;
            else                 status_q <= ST_TIMEOUT;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Load bookkeeping restarts with every run.
  always_ff @(posedge clk) begin
    if (rst || state_q == S_ARM) begin
      addr_err_q <= 1'b0;
      ir_cnt_q   <= '0;
      st_cnt_q   <= '0;
    end else if (accept) begin
      if (!addr_ok)      addr_err_q <= 1'b1;
      else if (host_sel) st_cnt_q   <= sat_inc(st_cnt_q);
      else               ir_cnt_q   <= sat_inc(ir_cnt_q);
    end
  end

  accel_wr_mux u_wr_mux (
    .clk        (clk),
    .rst        (rst),
    .host_fire_i(accept),
    .host_ok_i  (addr_ok),
    .host_sel_i (host_sel),
    .host_addr_i(host_addr),
    .host_data_i(host_data),
    .run_own_i  (run_own),
    .fsm_we_i   (fsm_we_i),
    .fsm_waddr_i(fsm_waddr_i),
    .fsm_wdata_i(fsm_wdata_i),
    .ir_we_o    (ir_we_o),
    .ir_waddr_o (ir_waddr_o),
    .ir_wdata_o (ir_wdata_o),
    .st_we_o    (st_we_o),
    .st_waddr_o (st_waddr_o),
    .st_wdata_o (st_wdata_o)
  );

  assign acc_start_o = acc_start_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign status_o    = status_q;
  assign addr_err_o  = addr_err_q;
  assign ir_cnt_o    = ir_cnt_q;
  assign st_cnt_o    = st_cnt_q;

endmodule

// File: tb/tb_accel_run_ctrl.sv
// Directed bench: main instance (DEPTH=16, TIMEOUT=32) plus a short-timeout twin (TIMEOUT=8).
module tb_accel_run_ctrl;

  logic        clk;
  logic        rst;
  logic        host_valid, host_sel, host_go, host_abort;
  logic [11:0] host_addr;
  logic [31:0] host_data;
  logic        fsm_we, acc_done;
  logic [11:0] fsm_waddr;
  logic [17:0] fsm_wdata;

  logic        host_ready, ir_we, st_we, acc_start, busy, done, addr_err;
  logic [11:0] ir_waddr, st_waddr;
  logic [31:0] ir_wdata;
  logic [17:0] st_wdata;
  logic [1:0]  status;
  logic [12:0] ir_cnt, st_cnt;

  logic        t_host_ready, t_ir_we, t_st_we, t_acc_start, t_busy, t_done, t_addr_err;
  logic [11:0] t_ir_waddr, t_st_waddr;
  logic [31:0] t_ir_wdata;
  logic [17:0] t_st_wdata;
  logic [1:0]  t_status;
  logic [12:0] t_ir_cnt, t_st_cnt;

  int total = 0;
  int bad   = 0;

  accel_run_ctrl #(.DEPTH(16), .TIMEOUT(32), .TO_W(6)) dut (
    .clk(clk), .rst(rst), .host_valid(host_valid), .host_ready(host_ready),
    .host_sel(host_sel), .host_addr(host_addr), .host_data(host_data),
    .host_go(host_go), .host_abort(host_abort),
    .ir_we_o(ir_we), .ir_waddr_o(ir_waddr), .ir_wdata_o(ir_wdata),
    .st_we_o(st_we), .st_waddr_o(st_waddr), .st_wdata_o(st_wdata),
    .fsm_we_i(fsm_we), .fsm_waddr_i(fsm_waddr), .fsm_wdata_i(fsm_wdata),
    .acc_start_o(acc_start), .acc_done_i(acc_done), .busy_o(busy), .done_o(done),
    .status_o(status), .addr_err_o(addr_err), .ir_cnt_o(ir_cnt), .st_cnt_o(st_cnt)
  );

  accel_run_ctrl #(.DEPTH(16), .TIMEOUT(8), .TO_W(4)) dut_to (
    .clk(clk), .rst(rst), .host_valid(host_valid), .host_ready(t_host_ready),
    .host_sel(host_sel), .host_addr(host_addr), .host_data(host_data),
    .host_go(host_go), .host_abort(host_abort),
    .ir_we_o(t_ir_we), .ir_waddr_o(t_ir_waddr), .ir_wdata_o(t_ir_wdata),
    .st_we_o(t_st_we), .st_waddr_o(t_st_waddr), .st_wdata_o(t_st_wdata),
    .fsm_we_i(fsm_we), .fsm_waddr_i(fsm_waddr), .fsm_wdata_i(fsm_wdata),
    .acc_start_o(t_acc_start), .acc_done_i(acc_done), .busy_o(t_busy), .done_o(t_done),
    .status_o(t_status), .addr_err_o(t_addr_err), .ir_cnt_o(t_ir_cnt), .st_cnt_o(t_st_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; host_valid = 0; host_sel = 0; host_addr = '0; host_data = '0;
    host_go = 0; host_abort = 0; fsm_we = 0; fsm_waddr = '0; fsm_wdata = '0; acc_done = 0;
    tick(); tick();
    rst = 1'b0;
    total++;
    if ({host_ready, busy, acc_start, done, addr_err, ir_we, st_we} !== 7'b1000000) begin
      bad++; $display("FAIL reset_ctrl got=%b want=1000000",
                      {host_ready, busy, acc_start, done, addr_err, ir_we, st_we});
    end
    total++;
    if ({status, ir_cnt, st_cnt} !== 28'd0) begin
      bad++; $display("FAIL reset_cnt got status=%b ir=%0d st=%0d want 0/0/0", status, ir_cnt, st_cnt);
    end
    $display("reset: ready=%b busy=%b", host_ready, busy);
  endtask

  task automatic test_load();
    host_valid = 1; host_sel = 0; host_addr = 12'd5; host_data = 32'hDEADBEEF;
    tick();
    total++;
    if ({ir_we, ir_waddr, ir_wdata, st_we} !== {1'b1, 12'd5, 32'hDEADBEEF, 1'b0}) begin
      bad++; $display("FAIL load_ir got we=%b a=%0d d=%h stwe=%b want 1/5/deadbeef/0",
                      ir_we, ir_waddr, ir_wdata, st_we);
    end
    host_sel = 1; host_addr = 12'd7; host_data = 32'h0002ABCD;
    tick();
    host_valid = 0;
    total++;
    if ({st_we, st_waddr, st_wdata, ir_we} !== {1'b1, 12'd7, 18'h2ABCD, 1'b0}) begin
      bad++; $display("FAIL load_st got we=%b a=%0d d=%h irwe=%b want 1/7/2abcd/0",
                      st_we, st_waddr, st_wdata, ir_we);
    end
    total++;
    if ({ir_cnt, st_cnt} !== {13'd1, 13'd1}) begin
      bad++; $display("FAIL load_cnt got ir=%0d st=%0d want 1/1", ir_cnt, st_cnt);
    end
    tick();
    total++;
    if (st_we !== 1'b0) begin
      bad++; $display("FAIL load_st_one_cycle got we=%b want 0", st_we);
    end
    $display("load: ir_cnt=%0d st_cnt=%0d", ir_cnt, st_cnt);
  endtask

  task automatic test_bad_addr();
    host_valid = 1; host_sel = 0; host_addr = 12'd20; host_data = 32'h11111111;
    total++;
    if (host_ready !== 1'b1) begin
      bad++; $display("FAIL bad_ready got=%b want 1", host_ready);
    end
    tick();
    host_valid = 0;
    total++;
    if ({ir_we, st_we, addr_err, ir_cnt} !== {1'b0, 1'b0, 1'b1, 13'd1}) begin
      bad++; $display("FAIL bad_addr got irwe=%b stwe=%b err=%b ircnt=%0d want 0/0/1/1",
                      ir_we, st_we, addr_err, ir_cnt);
    end
    host_go = 1;
    tick();
    host_go = 0;
    total++;
    if ({busy, host_ready, acc_start} !== 3'b100) begin
      bad++; $display("FAIL arm_state got busy/ready/start=%b want 100", {busy, host_ready, acc_start});
    end
    tick();
    total++;
    if ({addr_err, ir_cnt, st_cnt, acc_start} !== {1'b0, 13'd0, 13'd0, 1'b1}) begin
      bad++; $display("FAIL go_clears got err=%b ir=%0d st=%0d start=%b want 0/0/0/1",
                      addr_err, ir_cnt, st_cnt, acc_start);
    end
    host_abort = 1;
    tick();
    host_abort = 0;
    tick();
    $display("bad_addr: err cleared, status=%b", status);
  endtask

  task automatic test_timeout();
    host_go = 1;
    tick();
    host_go = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      total++;
      if ({t_acc_start, t_done} !== 2'b10) begin
        bad++; $display("FAIL timeout_run%0d got start/done=%b want 10", i, {t_acc_start, t_done});
      end
    end
    tick();
    total++;
    if ({t_acc_start, t_done, t_status, t_busy} !== 5'b0_1_01_1) begin
      bad++; $display("FAIL timeout_finish got start=%b done=%b status=%b busy=%b want 0/1/01/1",
                      t_acc_start, t_done, t_status, t_busy);
    end
    total++;
    if ({acc_start, status} !== 3'b1_00) begin
      bad++; $display("FAIL long_no_timeout got start=%b status=%b want 1/00", acc_start, status);
    end
    host_abort = 1;
    tick();
    host_abort = 0;
    total++;
    if ({status, done, t_status, t_done} !== 6'b10_1_01_0) begin
      bad++; $display("FAIL abort_outside_run got st=%b done=%b tst=%b tdone=%b want 10/1/01/0",
                      status, done, t_status, t_done);
    end
    tick();
    $display("timeout: status=%b", t_status);
  endtask

  task automatic test_normal_run();
    host_go = 1;
    tick();
    host_go = 0;
    tick();
    total++;
    if ({acc_start, host_ready} !== 2'b10) begin
      bad++; $display("FAIL run_start got start/ready=%b want 10", {acc_start, host_ready});
    end
    fsm_we = 1; fsm_waddr = 12'd3; fsm_wdata = 18'h00011;
    #1;
    total++;
    if ({st_we, st_waddr, st_wdata, ir_we} !== {1'b1, 12'd3, 18'h00011, 1'b0}) begin
      bad++; $display("FAIL run_passthru got we=%b a=%0d d=%h irwe=%b want 1/3/00011/0",
                      st_we, st_waddr, st_wdata, ir_we);
    end
    tick();
    fsm_we = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      total++;
      if ({host_ready, acc_start, done} !== 3'b010) begin
        bad++; $display("FAIL run_hold%0d got ready/start/done=%b want 010", i, {host_ready, acc_start, done});
      end
    end
    acc_done = 1;
    tick();
    acc_done = 0;
    total++;
    if ({done, status, acc_start, host_ready} !== 5'b1_00_0_0) begin
      bad++; $display("FAIL run_finish got done=%b status=%b start=%b ready=%b want 1/00/0/0",
                      done, status, acc_start, host_ready);
    end
    fsm_we = 1; fsm_waddr = 12'd9; fsm_wdata = 18'h3FFFF;
    #1;
    total++;
    if ({st_we, st_waddr, st_wdata} !== {1'b1, 12'd9, 18'h3FFFF}) begin
      bad++; $display("FAIL finish_writeback got we=%b a=%0d d=%h want 1/9/3ffff", st_we, st_waddr, st_wdata);
    end
    tick();
    total++;
    if ({st_we, done, host_ready, busy} !== 4'b0010) begin
      bad++; $display("FAIL idle_ignores_fsm got we/done/ready/busy=%b want 0010", {st_we, done, host_ready, busy});
    end
    fsm_we = 0;
    $display("normal_run: status=%b", status);
  endtask

  task automatic test_done_abort();
    host_go = 1; host_valid = 1; host_sel = 1; host_addr = 12'd4; host_data = 32'h00000155;
    tick();
    host_go = 0; host_valid = 0;
    total++;
    if ({st_we, st_waddr, st_wdata, st_cnt} !== {1'b1, 12'd4, 18'h00155, 13'd1}) begin
      bad++; $display("FAIL go_with_write got we=%b a=%0d d=%h cnt=%0d want 1/4/00155/1",
                      st_we, st_waddr, st_wdata, st_cnt);
    end
    tick();
    acc_done = 1; host_abort = 1;
    tick();
    acc_done = 0; host_abort = 0;
    total++;
    if ({done, status} !== 3'b1_00) begin
      bad++; $display("FAIL done_beats_abort got done=%b status=%b want 1/00", done, status);
    end
    tick();
    host_go = 1;
    tick();
    host_go = 0;
    tick();
    host_valid = 1; host_sel = 0; host_addr = 12'd2; host_data = 32'h00001234;
    tick();
    total++;
    if ({ir_we, ir_cnt, host_ready} !== {1'b0, 13'd0, 1'b0}) begin
      bad++; $display("FAIL run_write_blocked got irwe=%b cnt=%0d ready=%b want 0/0/0", ir_we, ir_cnt, host_ready);
    end
    host_abort = 1;
    tick();
    host_abort = 0;
    total++;
    if ({status, done, ir_we} !== 4'b10_1_0) begin
      bad++; $display("FAIL lone_abort got status=%b done=%b irwe=%b want 10/1/0", status, done, ir_we);
    end
    tick();
    tick();
    host_valid = 0;
    total++;
    if ({ir_we, ir_waddr, ir_wdata, ir_cnt} !== {1'b1, 12'd2, 32'h00001234, 13'd1}) begin
      bad++; $display("FAIL write_after_idle got we=%b a=%0d d=%h cnt=%0d want 1/2/00001234/1",
                      ir_we, ir_waddr, ir_wdata, ir_cnt);
    end
    $display("done_abort: status=%b", status);
  endtask

  task automatic test_reset_mid_run();
    host_go = 1;
    tick();
    host_go = 0;
    tick();
    total++;
    if (acc_start !== 1'b1) begin
      bad++; $display("FAIL rst_pre_run got start=%b want 1", acc_start);
    end
    rst = 1; fsm_we = 1; fsm_waddr = 12'd6; fsm_wdata = 18'h00ABC;
    tick();
    rst = 0;
    total++;
    if ({host_ready, busy, acc_start, done, st_we, ir_we, status} !== 8'b1000_0000) begin
      bad++; $display("FAIL rst_mid_run got=%b want 10000000",
                      {host_ready, busy, acc_start, done, st_we, ir_we, status});
    end
    tick();
    fsm_we = 0;
    total++;
    if ({done, acc_start, busy} !== 3'b000) begin
      bad++; $display("FAIL rst_no_done got done/start/busy=%b want 000", {done, acc_start, busy});
    end
    $display("reset_mid_run: ready=%b", host_ready);
  endtask

  initial begin
    test_reset();
    test_load();
    test_bad_addr();
    test_timeout();
    test_normal_run();
    test_done_abort();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
